// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter and IDLE/ISSUE/RESP sequencer (option: DMEM_ARB_ROUND_ROBIN_EN)
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              p0ReqValid,
  output logic              p0ReqReady,
  input  logic [ADDR_W-1:0] p0Addr,
  input  logic [DATA_W-1:0] p0Wdata,
  input  logic [2:0]        p0MemOp,
  input  logic              p0We,
  output logic              p0RespValid,
  output logic [DATA_W-1:0] p0Rdata,
  output logic              p0Err,
  input  logic              p1ReqValid,
  output logic              p1ReqReady,
  input  logic [ADDR_W-1:0] p1Addr,
  input  logic [DATA_W-1:0] p1Wdata,
  input  logic [2:0]        p1MemOp,
  input  logic              p1We,
  output logic              p1RespValid,
  output logic [DATA_W-1:0] p1Rdata,
  output logic              p1Err,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDin,
  output logic [2:0]        memOp,
  output logic              memWe,
  input  logic [DATA_W-1:0] memDout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        op_q, op_d;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic              err_q, err_d;

  logic              rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic              er0_q, er0_d, er1_q, er1_d;

  logic              grant0, grant1, prefer_p0, hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_op;
  logic              sel_we, sel_err, resp_fire;
  logic [DATA_W-1:0] rdata_fmt;

  // Illegal encodings, signed-size stores and misaligned halfword/word accesses.
  function automatic logic access_err(input logic [1:0] lo, input logic [2:0] op,
                                      input logic we);
    case (op)
      3'd0:    access_err = 1'b0;
      3'd4:    access_err = we;
      3'd1:    access_err = lo[0];
      3'd5:    access_err = we | lo[0];
      3'd2:    access_err = |lo;
      default: access_err = 1'b1;
    endcase
  endfunction

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Holds the id of the port granted last; reset value 1 lets p0 win first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (hs) last_d = grant1;
  end

  assign prefer_p0 = last_q;
`else
  assign prefer_p0 = 1'b1;
`endif

  assign grant0 = p0ReqValid & (~p1ReqValid | prefer_p0);
  assign grant1 = p1ReqValid & ~grant0;
  assign hs     = p0ReqReady | p1ReqReady;

  assign sel_addr  = grant1 ? p1Addr  : p0Addr;
  assign sel_wdata = grant1 ? p1Wdata : p0Wdata;
  assign sel_op    = grant1 ? p1MemOp : p0MemOp;
  assign sel_we    = grant1 ? p1We    : p0We;
  assign sel_err   = access_err(sel_addr[1:0], sel_op, sel_we);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    p0ReqReady = 1'b0;
    p1ReqReady = 1'b0;
    memWe      = 1'b0;
    if (rstn && (state_q == IDLE)) begin
      p0ReqReady = grant0;
      p1ReqReady = grant1;
    end
    if (state_q == ISSUE) memWe = we_q & ~err_q;
  end

  // Captured request; also feeds the memory, so it holds its last value when idle.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    we_d    = we_q;
    port_d  = port_q;
    err_d   = err_q;
    if (hs) begin
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      op_d    = sel_op;
      we_d    = sel_we;
      port_d  = grant1;
      err_d   = sel_err;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      we_q    <= we_d;
      port_q  <= port_d;
      err_q   <= err_d;
    end
  end

  // Response is sampled at the end of RESP and presented for exactly one cycle.
  assign resp_fire = (state_q == RESP);
  assign rdata_fmt = (resp_fire & ~we_q & ~err_q) ? memDout : '0;

  always_comb begin
    rv0_d = resp_fire & ~port_q;
    rv1_d = resp_fire & port_q;
    rd0_d = rv0_d ? rdata_fmt : '0;
    rd1_d = rv1_d ? rdata_fmt : '0;
    er0_d = rv0_d & err_q;
    er1_d = rv1_d & err_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
      er0_q <= 1'b0;
      er1_q <= 1'b0;
    end else begin
      rv0_q <= rv0_d;
      rv1_q <= rv1_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
      er0_q <= er0_d;
      er1_q <= er1_d;
    end
  end

  assign memAddr     = addr_q;
  assign memDin      = wdata_q;
  assign memOp       = op_q;
  assign p0RespValid = rv0_q;
  assign p1RespValid = rv1_q;
  assign p0Rdata     = rd0_q;
  assign p1Rdata     = rd1_q;
  assign p0Err       = er0_q;
  assign p1Err       = er1_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the data memory. Shares the memory between the CPU load/store unit (port 0) and the debug/program-loader port (port 1).
- Accepts one request at a time over a valid/ready handshake. Drives the memory's address, write-data, memOp and write-enable, and returns a registered response with load data or an error flag.
- Sits between the core/debug interconnect and the data memory. Both memory clock inputs are tied to clk.

Parameters:
- ADDR_W, 32, address width of requests and memAddr
- DATA_W, 32, data width of write/read data (only 32 supported)

Ports:
- clk  in  1  system clock; drives the memory read and write clocks
- rstn  in  1  asynchronous active-low reset
- p0ReqValid / p1ReqValid  in  1  request valid; hold stable until ready
- p0ReqReady / p1ReqReady  out  1  request accepted this cycle
- p0Addr / p1Addr  in  ADDR_W  byte address
- p0Wdata / p1Wdata  in  DATA_W  store data, LSB-aligned
- p0MemOp / p1MemOp  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU
- p0We / p1We  in  1  1=store, 0=load
- p0RespValid / p1RespValid  out  1  one-cycle response pulse
- p0Rdata / p1Rdata  out  DATA_W  load result; 0 for stores and errors
- p0Err / p1Err  out  1  misaligned or illegal op; valid with RespValid
- memAddr  out  ADDR_W  memory address
- memDin  out  DATA_W  memory write data
- memOp  out  3  memory access size/sign
- memWe  out  1  memory write enable
- memDout  in  DATA_W  formatted memory read data; valid one clock after the address is sampled

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE.
  - All outputs are 0, including memAddr, memDin, memOp, memWe, both Ready, both RespValid, both Rdata and both Err.
  - The round-robin pointer is set to favour p0.
  - Any in-flight request is dropped: no response, no write.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. The block is never idle-stalled.
- IDLE:
  - pXReqReady = (state==IDLE) & pXReqValid & grantX. This is combinational.
  - On a handshake, capture addr, wdata, memOp, we, the port id and the error check into registers. Next state is ISSUE.
- ISSUE (1 cycle):
  - memAddr, memDin, memOp are driven from the captured registers.
  - memWe = captured we & ~err.
  - The memory samples the read address, or commits the write, at the closing edge.
- RESP (1 cycle):
  - memAddr and memOp are still held, because memDout formatting depends on them. memWe = 0.
  - At the closing edge, register Rdata = (load & ~err) ? memDout : 0, and register Err.
  - Assert the granted port's RespValid for the following cycle, then return to IDLE.
- Timing:
  - Handshake in cycle N, RespValid in cycle N+3.
  - Maximum one request every 3 cycles.
  - A new handshake may coincide with the previous RespValid.
- Idle memory outputs: memAddr, memDin and memOp hold their last value. memWe = 0 outside ISSUE.
- Error conditions (err=1):
  - memOp in {3, 6, 7}.
  - Store with memOp 4 or 5.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - An erroring request still walks ISSUE and RESP (same latency) with memWe=0, Rdata=0 and Err=1.
- Arbitration is evaluated only in IDLE:
  - If only one port is valid, grant it.
  - If both are valid, use fixed priority p0, unless the optional feature is enabled.
  - The unchosen port waits with Ready=0 and must not drop Valid.
- Response outputs of the port not being answered stay 0.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register, reset to 1 so p0 wins first.
  - On a simultaneous request, grant the port not granted last.
  - The register updates on every handshake.
- Undefined: the register is absent and p0 always wins simultaneous requests.

Test Plan:
- Reset mid-op: p0 store SW addr 0x10 accepted, rstn low during ISSUE -> memWe falls immediately; no p0RespValid; a later LW 0x10 returns the prior contents.
- p0 SW addr 0x100 data 0xDEADBEEF, then p0 LW 0x100 -> memWe=1 exactly one cycle (cycle N+1); load p0RespValid at N+3, p0Rdata=0xDEADBEEF, p0Err=0.
- p1 SB addr 0x101 data 0x5A, then p1 LB 0x101 -> p1Rdata=0x0000005A; SB 0x102 data 0x80 then LB 0x102 -> 0xFFFFFF80, LBU -> 0x00000080.
- p0 LW addr 0x102 -> no memWe, p0RespValid at N+3 with p0Err=1, p0Rdata=0. Also p1 store with memOp=4 -> p1Err=1, memory unchanged.
- p0 and p1 both valid continuously for 12 cycles -> without the macro: 4 grants all p0, p1Ready=0. With the macro: grants alternate p0, p1, p0, p1.
- Back-to-back p0 requests -> handshakes at cycles 0, 3, 6; each RespValid coincides with the next handshake; Ready only in IDLE.
